// File: rtl/adaptive_filter_pkg.sv
// Shared types and helpers for the adaptive filter stages.
package adaptive_filter_pkg;

  localparam int DIFF_SCHED_COEFF_WL = 9;
  localparam int DIFF_SCHED_COEFF_FL = 7;

  typedef enum logic [1:0] {IDLE, MAC, OUT} diff_sched_state_t;

  // Clamp a signed value into the range of a wl-bit two's complement word.
  function automatic logic signed [63:0] sat_to_wl(input logic signed [63:0] value,
                                                   input int wl);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (wl - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (wl - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/adaptive_filter_mac_unit.sv
// Combinational pre-subtract, multiply and FL13->FL12 reduction for one tap pair.
// ADAPTIVE_FILTER_DIFF_ROUND_EN selects round-half-up instead of truncation.
module adaptive_filter_mac_unit #(
  parameter int DATA_WL  = 14,
  parameter int COEFF_WL = 9,
  parameter int PROD_W   = DATA_WL + COEFF_WL + 1
) (
  input  logic signed [DATA_WL-1:0]  x_new_i,
  input  logic signed [DATA_WL-1:0]  x_old_i,
  input  logic signed [COEFF_WL-1:0] coeff_i,
  output logic signed [PROD_W-1:0]   prod_o
);

  localparam int DIFF_W = DATA_WL + 1;

  logic signed [DIFF_W-1:0] diff;
  logic signed [PROD_W-1:0] full;

  assign diff = DIFF_W'(x_new_i) - DIFF_W'(x_old_i);
  assign full = PROD_W'(diff) * PROD_W'(coeff_i);

`ifdef ADAPTIVE_FILTER_DIFF_ROUND_EN
  // One extra bit so the rounding increment cannot wrap the product.
  logic signed [PROD_W:0] rnd;
  assign rnd    = (PROD_W + 1)'(full) + (PROD_W + 1)'(1);
  assign prod_o = PROD_W'(rnd >>> 1);
`else
  assign prod_o = full >>> 1;
`endif

endmodule

// File: rtl/adaptive_filter_diff_sched.sv
// Time-multiplexed antisymmetric FIR differentiator: one shared pre-subtract/MAC
// walks the tap pairs per sample. Rounding build: ADAPTIVE_FILTER_DIFF_ROUND_EN.
module adaptive_filter_diff_sched
  import adaptive_filter_pkg::*;
#(
  parameter int DATA_WL  = 14,
  parameter int DATA_FL  = 6,
  parameter int TAPS     = 10,
  parameter int COEFF_WL = DIFF_SCHED_COEFF_WL,
  parameter int COEFF_FL = DIFF_SCHED_COEFF_FL,
  parameter int OUT_WL   = 20,
  parameter int OUT_FL   = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_WL-1:0]    s_data,
  input  logic                         flush,
  output logic [$clog2(TAPS/2)-1:0]    coeff_sel,
  input  logic signed [COEFF_WL-1:0]   coeff,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [OUT_WL-1:0]     m_data,
  output logic                         busy
);

  localparam int PAIRS  = TAPS / 2;
  localparam int SEL_W  = $clog2(PAIRS);
  localparam int TIDX_W = $clog2(TAPS);
  localparam int PROD_W = DATA_WL + COEFF_WL + 1;
  // Product FL (DATA_FL + COEFF_FL - 1) equals OUT_FL, so no further alignment.
  localparam int SUM_W  = PROD_W + $clog2(PAIRS) + 1;
  localparam int ACC_W  = (SUM_W > OUT_WL + 4) ? SUM_W : OUT_WL + 4;

  diff_sched_state_t          state_q;
  logic [SEL_W-1:0]           cnt_q;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [DATA_WL-1:0]  x_q [TAPS];
  logic                       s_ready_q, m_valid_q, busy_q;
  logic signed [OUT_WL-1:0]   m_data_q, m_data_d;
  logic [TIDX_W-1:0]          new_idx, old_idx;
  logic signed [PROD_W-1:0]   prod;

  assign new_idx = TIDX_W'(cnt_q);
  assign old_idx = TIDX_W'(TAPS - 1) - TIDX_W'(cnt_q);

  adaptive_filter_mac_unit #(
    .DATA_WL (DATA_WL),
    .COEFF_WL(COEFF_WL),
    .PROD_W  (PROD_W)
  ) u_mac (
    .x_new_i(x_q[new_idx]),
    .x_old_i(x_q[old_idx]),
    .coeff_i(coeff),
    .prod_o (prod)
  );

  assign acc_d    = acc_q + ACC_W'(prod);
  assign m_data_d = OUT_WL'(sat_to_wl(64'(acc_q), OUT_WL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_valid && s_ready_q) begin
            x_q[0] <= s_data;
            for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
            cnt_q     <= '0;
            acc_q     <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= MAC;
          end else if (flush) begin
            for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (cnt_q == SEL_W'(PAIRS - 1)) state_q <= OUT;
          else                            cnt_q   <= cnt_q + 1'b1;
        end
        OUT: begin
          // First OUT cycle registers the saturated result; it then holds until taken.
          if (!m_valid_q) begin
            m_valid_q <= 1'b1;
            m_data_q  <= m_data_d;
          end else if (m_ready) begin
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign busy      = busy_q;
  assign coeff_sel = cnt_q;

endmodule
